mux_nsel_pipe: RTL

- Parametrised successor to the 4-way datapath select mux.
- N-channel, WIDTH-bit selector with per-channel valid/ready inputs and a single registered output stage with valid/ready.
- Two modes: explicit select (drop-in for the datapath mux) and round-robin arbitration among valid channels.
- Used wherever multiple producers (forwarding, writeback, memory return) share one consumer.

---
 rtl/mux_pkg.sv | 5 +
 rtl/mux_nsel_pipe_rr_pick.sv | 26 ++
 rtl/mux_nsel_pipe.sv | 78 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings for the N-channel select/arbitrate mux.
package mux_pkg;
   localparam logic MUX_MODE_SEL = 1'b0;
   localparam logic MUX_MODE_RR  = 1'b1;
endpackage

// File: rtl/mux_nsel_pipe_rr_pick.sv
// rr_pick: rotate-priority encoder; first set req bit after ptr, wrapping mod N.
//   req       : per-channel request
//   ptr       : last granted channel (search starts at ptr+1)
//   gnt_valid : some request is set
//   gnt_idx   : granted channel index
module rr_pick #(
   parameter  int N     = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);
   // Scan farthest-first so the nearest candidate after ptr is written last and wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = N; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SEL_W'((int'(ptr) + i) % N);
         end
      end
   end
endmodule

// File: rtl/mux_nsel_pipe.sv
// mux_nsel_pipe: N-way select or round-robin mux with one registered valid/ready output stage.
//   clk, rst (async, active-low)
//   mode      : MUX_MODE_SEL explicit select, MUX_MODE_RR round-robin
//   select    : channel index in select mode
//   in_valid/in_data/in_ready : per-channel handshake, channel k at in_data[k*WIDTH +: WIDTH]
//   out_valid/out_data/out_ready : registered output handshake
//   out_idx   : source channel of out_data, present only with MUX_NSEL_OUT_IDX_EN
module mux_nsel_pipe
   import mux_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SEL_W-1:0]   select,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready
`ifdef MUX_NSEL_OUT_IDX_EN
   ,
   output logic [SEL_W-1:0]   out_idx
`endif
);
   localparam int NP = 1 << SEL_W;
   logic [NP-1:0]    valid_ext;
   logic [SEL_W-1:0] rr_ptr;
   logic             rr_valid;
   logic [SEL_W-1:0] rr_idx;
   logic             gnt_valid;
   logic [SEL_W-1:0] gnt_idx;
   logic             can_load;
   logic             xfer;

   rr_pick #(.N(N)) u_rr_pick (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   // Zero-padded to a power of two so select values >= N read a 0 and never grant.
   assign valid_ext = NP'(in_valid);

   always_comb begin
      gnt_valid = (mode == MUX_MODE_RR) ? rr_valid : valid_ext[select];
      gnt_idx   = (mode == MUX_MODE_RR) ? rr_idx : select;
      can_load  = !out_valid || out_ready;
      xfer      = gnt_valid && can_load;
      in_ready  = (rst && xfer) ? (N'(1) << gnt_idx) : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         rr_ptr    <= SEL_W'(N - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(gnt_idx) * WIDTH +: WIDTH];
         rr_ptr    <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MUX_NSEL_OUT_IDX_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_idx <= '0;
      else if (xfer) out_idx <= gnt_idx;
   end
`endif
endmodule
